// File: rtl/xbar_slave_mem.sv
// xbar_slave_mem: word-addressed SRAM endpoint that terminates one crossbar slave port.
// The FSM accepts req/ack handshakes. Writes go straight to memory. Reads capture the
// word at handshake time and return it READ_LATENCY cycles later through an in-order
// pending-read queue.
// Build option XBAR_SLAVE_MEM_RANDOM_ACK_EN: the ack delay is drawn from an 8-bit LFSR
// (values 0..7) instead of the fixed ACK_DELAY.
module xbar_slave_mem #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MEM_DEPTH       = 256,
    parameter int ACK_DELAY       = 1,
    parameter int READ_LATENCY    = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  cmd,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ack,
    output logic                  resp,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int               IDX_W      = $clog2(MEM_DEPTH);
    localparam int               PTR_W      = $clog2(MAX_OUTSTANDING);
    localparam logic [2:0]       DLY_LOAD   = 3'(ACK_DELAY);
    localparam logic [3:0]       LAT_LOAD   = 4'(READ_LATENCY - 1);
    localparam logic [PTR_W:0]   Q_FULL_CNT = (PTR_W+1)'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    state_t                  state, state_nxt;
    logic [2:0]              delay_cnt, delay_nxt, delay_load;
    logic [DATA_WIDTH-1:0]   mem    [MEM_DEPTH];
    logic [DATA_WIDTH-1:0]   q_data [MAX_OUTSTANDING];
    logic [3:0]              q_lat  [MAX_OUTSTANDING];
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic [PTR_W:0]          q_cnt;
    logic [IDX_W-1:0]        word_idx;
    logic                    hs, wr_en, q_push, q_pop, q_full;
    logic                    unused_addr_bits;

    // Only the word-index bits select a location; byte offset and upper bits alias.
    assign word_idx         = addr[IDX_W+1:2];
    assign unused_addr_bits = ^{addr[ADDR_WIDTH-1:IDX_W+2], addr[1:0]};

    // ack comes straight from the state register, so it is glitch-free toward the crossbar.
    assign ack    = (state == ST_ACK);
    assign hs     = ack & req;
    assign wr_en  = hs & cmd;
    assign q_push = hs & ~cmd;
    assign q_full = (q_cnt == Q_FULL_CNT);
    // Entries are pushed at least two cycles apart, so only the head can be due.
    assign q_pop  = (q_cnt != '0) && (q_lat[rd_ptr] == 4'd0);

`ifdef XBAR_SLAVE_MEM_RANDOM_ACK_EN
    logic [7:0] lfsr;

    // Fibonacci LFSR, taps 8,6,5,4, free-running to randomise the ack hold time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 8'hA5;
        else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign delay_load = lfsr[2:0];
`else
    assign delay_load = DLY_LOAD;
`endif

    // FSM state and ack-delay counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            delay_cnt <= 3'd0;
        end else begin
            state     <= state_nxt;
            delay_cnt <= delay_nxt;
        end
    end

    // Next state: count down the ack delay, hold reads while the queue is full.
    always_comb begin
        state_nxt = state;
        delay_nxt = delay_cnt;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = ST_WAIT;
                    delay_nxt = delay_load;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    state_nxt = ST_IDLE;
                end else if (delay_cnt == 3'd0) begin
                    if (cmd || !q_full) state_nxt = ST_ACK;
                end else begin
                    delay_nxt = delay_cnt - 3'd1;
                end
            end
            ST_ACK: begin
                if (req) begin
                    state_nxt = ST_WAIT;
                    delay_nxt = delay_load;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Memory array; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[word_idx] <= wdata;
    end

    // Queue payload: capture read data at the handshake, count every entry down.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (q_push && wr_ptr == PTR_W'(i)) begin
                q_data[i] <= mem[word_idx];
                q_lat[i]  <= LAT_LOAD;
            end else if (q_lat[i] != 4'd0) begin
                q_lat[i]  <= q_lat[i] - 4'd1;
            end
        end
    end

    // Queue pointers and occupancy; reset drops every pending read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (q_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (q_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({q_push, q_pop})
                2'b10:   q_cnt <= q_cnt + (PTR_W+1)'(1);
                2'b01:   q_cnt <= q_cnt - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

    // Response register: one-cycle resp pulse with the popped word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp  <= 1'b0;
            rdata <= '0;
        end else begin
            resp <= q_pop;
            if (q_pop) rdata <= q_data[rd_ptr];
        end
    end

endmodule

// File: tb/tb_xbar_slave_mem.sv
// Testbench for xbar_slave_mem. u_dut uses default parameters. u_full uses
// READ_LATENCY=15 and ACK_DELAY=0 so that the pending-read queue can be filled.
// sel routes the shared master signals to one instance at a time.
module tb_xbar_slave_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0, cmd = 1'b0, sel = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic        req0, req1, ack0, ack1, resp0, resp1;
    logic [31:0] rdata0, rdata1;
    logic        cur_ack, cur_resp;
    logic [31:0] cur_rdata;

    int          cyc = 0;
    int          n_chk = 0, n_err = 0, bad_ack = 0;
    logic [31:0] rsp_data[$];
    int          rsp_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign req0      = req & ~sel;
    assign req1      = req & sel;
    assign cur_ack   = sel ? ack1 : ack0;
    assign cur_resp  = sel ? resp1 : resp0;
    assign cur_rdata = sel ? rdata1 : rdata0;

    xbar_slave_mem u_dut (
        .clk(clk), .rst_n(rst_n), .req(req0), .addr(addr), .cmd(cmd), .wdata(wdata),
        .ack(ack0), .resp(resp0), .rdata(rdata0)
    );

    xbar_slave_mem #(.ACK_DELAY(0), .READ_LATENCY(15), .MAX_OUTSTANDING(4)) u_full (
        .clk(clk), .rst_n(rst_n), .req(req1), .addr(addr), .cmd(cmd), .wdata(wdata),
        .ack(ack1), .resp(resp1), .rdata(rdata1)
    );

    // Record responses of the selected slave and any ack seen without its req.
    always @(negedge clk) begin
        if (cur_resp) begin
            rsp_data.push_back(cur_rdata);
            rsp_cyc.push_back(cyc);
        end
        if ((ack0 && !req0) || (ack1 && !req1)) bad_ack++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge. lat counts edges from the first edge that
    // samples req to the edge that raises ack; hs is the handshake edge index.
    task automatic do_req(input logic c, input logic [31:0] a, input logic [31:0] d,
                          input bit keep, output int lat, output int hs);
        int s;
        bit got;
        s = cyc; req = 1'b1; cmd = c; addr = a; wdata = d;
        got = 1'b0; lat = -1; hs = -1;
        for (int i = 0; i < 64 && !got; i++) begin
            @(negedge clk);
            if (cur_ack) begin
                got = 1'b1;
                lat = cyc - (s + 1);
            end
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        hs = cyc;
        if (!keep || !got) begin
            req = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_resp(input int n);
        for (int i = 0; i < 200 && rsp_data.size() < n; i++) @(negedge clk);
        if (rsp_data.size() < n) check("resp_timeout", rsp_data.size(), n);
        @(posedge clk); #1;
    endtask

    // Single read from idle; checks data and resp distance from the handshake.
    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp,
                              input int exp_rlat);
        int lat, hs, idx;
        idx = rsp_data.size();
        do_req(1'b0, a, 32'd0, 1'b0, lat, hs);
        wait_resp(idx + 1);
        if (rsp_data.size() > idx) begin
            check({tag, "_data"}, rsp_data[idx], exp);
`ifndef XBAR_SLAVE_MEM_RANDOM_ACK_EN
            check({tag, "_rlat"}, rsp_cyc[idx] - hs, exp_rlat);
`endif
        end
    endtask

    initial begin
        int lat, hs, base, nb;
        int hsv[6];
        int w_hs;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack0", ack0, 0);
        check("rst_resp0", resp0, 0);
        check("rst_rdata0", rdata0, 0);
        check("rst_ack1", ack1, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Write then read on the default instance (ACK_DELAY=1, READ_LATENCY=2).
        sel = 1'b0;
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, hs);
`ifndef XBAR_SLAVE_MEM_RANDOM_ACK_EN
        check("wr_ack_lat", lat, 2);
`endif
        read_check("rd_10", 32'h10, 32'hDEADBEEF, 2);

        // Address aliasing: 0x401 maps to word 0, 0xFFFFFC10 maps to word 4.
        do_req(1'b1, 32'h0000_0401, 32'h5A5A1234, 1'b0, lat, hs);
        read_check("alias_0", 32'h0, 32'h5A5A1234, 2);
        read_check("word4_keep", 32'h10, 32'hDEADBEEF, 2);
        do_req(1'b1, 32'hFFFF_FC10, 32'h0F0F0F0F, 1'b0, lat, hs);
        read_check("alias_4", 32'h10, 32'h0F0F0F0F, 2);

        // Read after write on consecutive handshakes with req held.
        do_req(1'b1, 32'h20, 32'h11112222, 1'b1, lat, hs);
        read_check("raw_20", 32'h20, 32'h11112222, 2);

        // Prefill words 0..5 of u_full with 0x100..0x105.
        sel = 1'b1;
        for (int i = 0; i < 6; i++) do_req(1'b1, 32'(i * 4), 32'h100 + 32'(i), 1'b0, lat, hs);

        // Six pipelined reads with req held: four back-to-back, the fifth waits for the first resp.
        base = rsp_data.size();
        for (int i = 0; i < 6; i++) do_req(1'b0, 32'(i * 4), 32'd0, (i < 5), lat, hsv[i]);
        wait_resp(base + 6);
        for (int i = 0; i < 6; i++)
            if (rsp_data.size() > base + i) check($sformatf("pipe_data%0d", i), rsp_data[base + i], 32'h100 + 32'(i));
`ifndef XBAR_SLAVE_MEM_RANDOM_ACK_EN
        if (rsp_data.size() > base) begin
            nb = 0;
            for (int i = 0; i < 6; i++) if (hsv[i] < rsp_cyc[base]) nb++;
            check("pipe_acks_before_resp", nb, 4);
            check("pipe_ack5_after_drain", hsv[4], rsp_cyc[base] + 2);
            check("pipe_spacing", hsv[1] - hsv[0], 2);
            check("pipe_rlat", rsp_cyc[base] - hsv[0], 15);
        end
`endif

        // Full queue, then a write: it is acked without waiting for the queue to drain.
        base = rsp_data.size();
        for (int i = 0; i < 4; i++) do_req(1'b0, 32'(i * 4), 32'd0, 1'b1, lat, hsv[i]);
        do_req(1'b1, 32'h20, 32'hCAFE0008, 1'b0, lat, w_hs);
        wait_resp(base + 4);
`ifndef XBAR_SLAVE_MEM_RANDOM_ACK_EN
        check("full_write_hs", w_hs - hsv[3], 2);
        if (rsp_data.size() > base) check("full_write_before_resp", (w_hs < rsp_cyc[base]), 1);
`endif
        for (int i = 0; i < 4; i++)
            if (rsp_data.size() > base + i) check($sformatf("full_data%0d", i), rsp_data[base + i], 32'h100 + 32'(i));
        read_check("full_write_mem", 32'h20, 32'hCAFE0008, 15);

        // Read data is captured at the handshake; a following write to the same word does not alter it.
        base = rsp_data.size();
        do_req(1'b0, 32'h0, 32'd0, 1'b1, lat, hs);
        do_req(1'b1, 32'h0, 32'h0BADF00D, 1'b0, lat, hs);
        wait_resp(base + 1);
        if (rsp_data.size() > base) check("capture_old", rsp_data[base], 32'h100);
        read_check("capture_new", 32'h0, 32'h0BADF00D, 15);

        // Reset one cycle after two read handshakes: pending reads vanish.
        do_req(1'b0, 32'h4, 32'd0, 1'b1, lat, hs);
        do_req(1'b0, 32'h8, 32'd0, 1'b1, lat, hs);
        @(posedge clk); #1;
        req = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_ack", ack1, 0);
        check("midrst_resp", resp1, 0);
        check("midrst_rdata", rdata1, 0);
        base = rsp_data.size();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (25) @(posedge clk);
        #1;
        check("midrst_no_resp", rsp_data.size() - base, 0);
        read_check("post_rst_mem", 32'h10, 32'h104, 15);

`ifdef XBAR_SLAVE_MEM_RANDOM_ACK_EN
        begin
            bit seen[8];
            int nd;
            sel = 1'b0;
            for (int i = 0; i < 8; i++) seen[i] = 1'b0;
            for (int i = 0; i < 25; i++) begin
                do_req(1'b1, 32'h40 + 32'(i * 4), 32'h01010101 * 32'(i + 1), 1'b0, lat, hs);
                if (lat >= 1 && lat <= 8) seen[lat - 1] = 1'b1;
                read_check($sformatf("rnd%0d", i), 32'h40 + 32'(i * 4), 32'h01010101 * 32'(i + 1), 2);
            end
            nd = 0;
            for (int i = 0; i < 8; i++) if (seen[i]) nd++;
            check("rnd_distinct_ge4", (nd >= 4), 1);
        end
`endif

        check("ack_without_req", bad_ack, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/xbar_slave_mem.md
Name: xbar_slave_mem

Overview:
- Slave-side endpoint that sits directly downstream of the 4x4 crossbar and terminates one crossbar slave port.
- Models a word-addressed SRAM. It accepts request handshakes, applies writes, and returns read data after a fixed latency through an in-order pending-read queue.
- Four instances serve as slaves 0..3 in crossbar integration benches.

Parameters:
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, write/read data width
- MEM_DEPTH, 256, number of DATA_WIDTH words; power of 2, minimum 4
- ACK_DELAY, 1, cycles between req observed and ack asserted; range 0..7
- READ_LATENCY, 2, cycles from read handshake to resp; range 1..15
- MAX_OUTSTANDING, 4, depth of the pending-read queue; power of 2, minimum 2

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req  input  1  request valid from crossbar
- addr  input  ADDR_WIDTH  byte address
- cmd  input  1  0 = read, 1 = write
- wdata  input  DATA_WIDTH  write data
- ack  output  1  request accepted
- resp  output  1  read data valid, one-cycle pulse
- rdata  output  DATA_WIDTH  read data; valid only while resp=1

Behaviour:
- Reset, asynchronous on rst_n low:
  - ack=0, resp=0, rdata=0.
  - FSM goes to IDLE and the pending-read queue is flushed.
  - Memory contents are not cleared.
  - A reset mid-transaction drops all pending reads; no resp is issued for them after reset.
- Handshake:
  - A transfer occurs on a clock edge where req=1 and ack=1.
  - addr, cmd and wdata are sampled only at the handshake.
  - req is held by the master until ack; ack is never asserted while req=0.
- Word index is addr[$clog2(MEM_DEPTH)+1:2]. Upper address bits and addr[1:0] are ignored.
- FSM:
  - IDLE: on req=1 go to WAIT, loading delay_cnt=ACK_DELAY.
  - WAIT: decrement delay_cnt each cycle. When delay_cnt==0 and (cmd=1 or queue not full), go to ACK.
  - ACK:
    - Drive ack=1 for exactly one cycle (the handshake cycle).
    - If req=1 remains next cycle, go to WAIT with a reload; otherwise go to IDLE.
  - ack is registered (driven from state), so minimum req-to-ack latency is ACK_DELAY+1 cycles.
  - With ACK_DELAY=0, back-to-back requests are acked every 2 cycles.
  - req dropping while in WAIT (protocol violation) returns the FSM to IDLE without ack.
- Write: on the handshake, mem[index] <= wdata. No resp is issued for writes.
- Read:
  - On the handshake, mem[index] is read and pushed with a countdown of READ_LATENCY-1.
  - The data is captured at handshake time, so a later write to the same word does not alter it.
  - Every queue entry counts down each cycle.
  - When the head entry's count is 0, it is popped with resp=1 and rdata=data on the next cycle.
  - Total latency is exactly READ_LATENCY cycles after the handshake edge.
- Queue full: a read whose handshake would overflow the queue is held in WAIT (ack withheld). A write is never blocked by a full queue.
- A push and a pop in the same cycle are both allowed; occupancy is unchanged.
- Responses are strictly in request order. Only one resp pulse per cycle.
- Read-after-write to the same word on consecutive handshakes returns the new data.

Optional Feature:
- Macro: XBAR_SLAVE_MEM_RANDOM_ACK_EN
- Defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 8'hA5 on reset) advances every cycle.
  - On the IDLE->WAIT and ACK->WAIT transitions, delay_cnt is loaded from lfsr[2:0] instead of ACK_DELAY. The delay therefore varies from 0 to 7.
  - This stresses crossbar arbitration hold behaviour.
- Not defined: delay_cnt always loads ACK_DELAY; no LFSR logic is present.

Test Plan:
- Write then read: write addr 0x10, wdata 0xDEADBEEF; then read addr 0x10 -> ack ACK_DELAY+1 cycles after each req; resp with rdata 0xDEADBEEF exactly 2 cycles after the read handshake.
- Pipelined reads: MAX_OUTSTANDING=4; prefill words 0..5 with 0x100..0x105; req held for 6 reads -> 4 reads acked back-to-back; further acks resume only as resps drain; 6 resps in order 0x100..0x105.
- Full queue with write: queue full, then a write request -> write acked without waiting; memory updated.
- Ignored address bits: write addr 0x0000_0401 with MEM_DEPTH=256 -> aliases to word 0; reading addr 0x0 returns the written data.
- Reset mid-operation: pulse rst_n low 1 cycle after 2 read handshakes -> no resp ever issued; ack=0, resp=0, rdata=0 immediately; next request serviced normally.
- Random ack (macro defined): 50 writes/reads -> ack delays span at least 4 distinct values in 0..7; all read data correct; ack never asserted with req=0.
